// File: rtl/trap_sequencer.sv
// Machine-mode trap/interrupt sequencer: arbitrates exceptions, interrupts and mret, strobes the CSR file
// and redirects fetch. Optional vectored interrupt targets under `TRAP_VECTORED_EN.
module trap_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exc_valid_i,
  input  logic [3:0]  exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic        mret_i,
  input  logic        retire_i,
  input  logic [31:0] next_pc_i,
  input  logic        int_meip_i,
  input  logic        int_mtip_i,
  input  logic        int_msip_i,
  input  logic        mie_meie_i,
  input  logic        mie_mtie_i,
  input  logic        mie_msie_i,
  input  logic        mstatus_mie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic        fetch_ready_i,
  output logic        ack_o,
  output logic        busy_o,
  output logic        flush_o,
  output logic        csr_trap_o,
  output logic        csr_interrupt_o,
  output logic [3:0]  csr_cause_o,
  output logic [31:0] csr_pc_o,
  output logic        csr_mret_o,
  output logic        pc_load_o,
  output logic [31:0] pc_target_o
);

  typedef enum logic [1:0] {IDLE, ENTER, MRET, REDIRECT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cause_q, cause_d;
  logic        intr_q, intr_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] ret_q, ret_d;
  logic [31:0] target_q, target_d;
  logic        trap_q, mret_q, flush_q;
  logic        ack;

  logic        mei_en, msi_en, mti_en, irq_take;
  logic [3:0]  irq_cause;
  logic [31:0] vec_base, vec_target;

  assign mei_en   = int_meip_i & mie_meie_i;
  assign msi_en   = int_msip_i & mie_msie_i;
  assign mti_en   = int_mtip_i & mie_mtie_i;
  assign irq_take = mstatus_mie_i & retire_i & (mei_en | msi_en | mti_en);
  // Interrupt priority is MEI > MSI > MTI, which is not numeric cause order.
  assign irq_cause = mei_en ? 4'd11 : (msi_en ? 4'd3 : 4'd7);

  assign vec_base = {mtvec_i[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
  assign vec_target = (intr_q && (mtvec_i[1:0] == 2'b01))
                      ? vec_base + {26'd0, cause_q, 2'b00}
                      : vec_base;
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec_i[1:0];
  assign vec_target = vec_base;
`endif

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    intr_d   = intr_q;
    epc_d    = epc_q;
    ret_d    = ret_q;
    target_d = target_q;
    ack      = 1'b0;
    case (state_q)
      IDLE: begin
        if (exc_valid_i) begin
          ack     = 1'b1;
          cause_d = exc_cause_i;
          intr_d  = 1'b0;
          epc_d   = {exc_pc_i[31:2], 2'b00};
          state_d = ENTER;
        end else if (irq_take) begin
          ack     = 1'b1;
          cause_d = irq_cause;
          intr_d  = 1'b1;
          epc_d   = {next_pc_i[31:2], 2'b00};
          state_d = ENTER;
        end else if (mret_i) begin
          ack     = 1'b1;
          ret_d   = mepc_i;
          state_d = MRET;
        end
      end
      ENTER: begin
        target_d = vec_target;
        state_d  = REDIRECT;
      end
      MRET: begin
        target_d = ret_q;
        state_d  = REDIRECT;
      end
      REDIRECT: begin
        if (fetch_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cause_q  <= 4'd0;
      intr_q   <= 1'b0;
      epc_q    <= 32'd0;
      ret_q    <= 32'd0;
      target_q <= RESET_PC;
      trap_q   <= 1'b0;
      mret_q   <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      intr_q   <= intr_d;
      epc_q    <= epc_d;
      ret_q    <= ret_d;
      target_q <= target_d;
      trap_q   <= (state_d == ENTER);
      mret_q   <= (state_d == MRET);
      flush_q  <= (state_d == ENTER) || (state_d == MRET);
    end
  end

  assign ack_o           = ack & ~rst_i;
  assign busy_o          = (state_q != IDLE);
  assign flush_o         = flush_q;
  assign csr_trap_o      = trap_q;
  assign csr_mret_o      = mret_q;
  assign csr_interrupt_o = intr_q;
  assign csr_cause_o     = cause_q;
  assign csr_pc_o        = epc_q;
  assign pc_load_o       = (state_q == REDIRECT);
  assign pc_target_o     = target_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios plus randomized traffic against a timestamp-based model.
module tb_trap_sequencer;
  localparam logic [31:0] RST_PC = 32'h0000_8000;
  localparam int NEVER = 32'h3fff_ffff;
`ifdef TRAP_VECTORED_EN
  localparam bit VEC_EN = 1'b1;
`else
  localparam bit VEC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_i, exc_valid_i, mret_i, retire_i, fetch_ready_i;
  logic [3:0] exc_cause_i;
  logic [31:0] exc_pc_i, next_pc_i, mtvec_i, mepc_i;
  logic int_meip_i, int_mtip_i, int_msip_i, mie_meie_i, mie_mtie_i, mie_msie_i, mstatus_mie_i;
  logic ack_o, busy_o, flush_o, csr_trap_o, csr_interrupt_o, csr_mret_o, pc_load_o;
  logic [3:0] csr_cause_o;
  logic [31:0] csr_pc_o, pc_target_o;

  always #5 clk = ~clk;

  trap_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk_i(clk), .rst_i(rst_i), .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i),
    .exc_pc_i(exc_pc_i), .mret_i(mret_i), .retire_i(retire_i), .next_pc_i(next_pc_i),
    .int_meip_i(int_meip_i), .int_mtip_i(int_mtip_i), .int_msip_i(int_msip_i),
    .mie_meie_i(mie_meie_i), .mie_mtie_i(mie_mtie_i), .mie_msie_i(mie_msie_i),
    .mstatus_mie_i(mstatus_mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .fetch_ready_i(fetch_ready_i), .ack_o(ack_o), .busy_o(busy_o), .flush_o(flush_o),
    .csr_trap_o(csr_trap_o), .csr_interrupt_o(csr_interrupt_o), .csr_cause_o(csr_cause_o),
    .csr_pc_o(csr_pc_o), .csr_mret_o(csr_mret_o), .pc_load_o(pc_load_o), .pc_target_o(pc_target_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: a transaction accepted at cycle acc strobes at acc+1, loads fetch from acc+2 until the
  // handshake cycle, and the block is free again at free_at.
  int cyc = 0;
  int acc = -100;
  int free_at = 0;
  bit m_trap, m_int;
  logic [3:0] m_cause;
  logic [31:0] m_pc, m_ret;
  logic [31:0] m_target = RST_PC;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_target(input logic [31:0] mtvec, input bit intr,
                                             input logic [3:0] cause);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (VEC_EN && intr && mtvec[1:0] == 2'b01) return base + 32'(cause) * 32'd4;
    return base;
  endfunction

  task automatic model_check();
    bit idle, e_ack, e_trap, e_mret, e_load, ipend;
    logic [3:0] icause;
    if (rst_i) begin
      acc = -100;
      free_at = cyc + 1;
      m_target = RST_PC;
      return;
    end
    idle   = (cyc >= free_at);
    ipend  = mstatus_mie_i && retire_i && ((int_meip_i && mie_meie_i) ||
             (int_msip_i && mie_msie_i) || (int_mtip_i && mie_mtie_i));
    icause = (int_meip_i && mie_meie_i) ? 4'd11 : (int_msip_i && mie_msie_i) ? 4'd3 : 4'd7;
    e_ack  = 1'b0;
    if (idle) begin
      if (exc_valid_i) begin
        e_ack = 1'b1; m_trap = 1'b1; m_int = 1'b0; m_cause = exc_cause_i;
        m_pc = {exc_pc_i[31:2], 2'b00};
      end else if (ipend) begin
        e_ack = 1'b1; m_trap = 1'b1; m_int = 1'b1; m_cause = icause;
        m_pc = {next_pc_i[31:2], 2'b00};
      end else if (mret_i) begin
        e_ack = 1'b1; m_trap = 1'b0; m_ret = mepc_i;
      end
      if (e_ack) begin
        acc = cyc;
        free_at = NEVER;
      end
    end
    e_trap = m_trap && (cyc == acc + 1);
    e_mret = !m_trap && (cyc == acc + 1);
    e_load = (acc >= 0) && (cyc >= acc + 2) && (cyc < free_at);
    check("ack", 32'(ack_o), 32'(e_ack));
    check("busy", 32'(busy_o), 32'(!idle));
    check("flush", 32'(flush_o), 32'(e_trap || e_mret));
    check("trap", 32'(csr_trap_o), 32'(e_trap));
    check("mret", 32'(csr_mret_o), 32'(e_mret));
    check("pc_load", 32'(pc_load_o), 32'(e_load));
    check("pc_target", pc_target_o, m_target);
    if (e_trap) begin
      check("cause", 32'(csr_cause_o), 32'(m_cause));
      check("intr", 32'(csr_interrupt_o), 32'(m_int));
      check("csr_pc", csr_pc_o, m_pc);
    end
    if (cyc == acc + 1) m_target = m_trap ? ref_target(mtvec_i, m_int, m_cause) : m_ret;
    if (e_load && fetch_ready_i) free_at = cyc + 1;
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs();
    rst_i = 1'b0; exc_valid_i = 1'b0; exc_cause_i = 4'd0; exc_pc_i = 32'd0;
    mret_i = 1'b0; retire_i = 1'b0; next_pc_i = 32'd0;
    int_meip_i = 1'b0; int_mtip_i = 1'b0; int_msip_i = 1'b0;
    mie_meie_i = 1'b0; mie_mtie_i = 1'b0; mie_msie_i = 1'b0; mstatus_mie_i = 1'b0;
    mtvec_i = 32'h0000_0100; mepc_i = 32'd0; fetch_ready_i = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst_i = 1'b1;
    @(posedge clk); #1;
    step();
    rst_i = 1'b0;
    check("rst_target", pc_target_o, RST_PC);
    check("rst_busy", 32'(busy_o), 32'd0);
    step();

    // Exception with misaligned PC
    exc_valid_i = 1'b1; exc_cause_i = 4'd2; exc_pc_i = 32'h0000_1006;
    step();
    exc_valid_i = 1'b0;
    check("t1_trap", 32'(csr_trap_o), 32'd1);
    check("t1_cause", 32'(csr_cause_o), 32'd2);
    check("t1_pc", csr_pc_o, 32'h0000_1004);
    check("t1_intr", 32'(csr_interrupt_o), 32'd0);
    step();
    check("t1_target", pc_target_o, 32'h0000_0100);
    repeat (2) step();

    // Interrupt priority
    int_meip_i = 1'b1; int_msip_i = 1'b1; int_mtip_i = 1'b1;
    mie_meie_i = 1'b1; mie_msie_i = 1'b1; mie_mtie_i = 1'b1;
    mstatus_mie_i = 1'b1; retire_i = 1'b1; next_pc_i = 32'h0000_4000;
    step();
    check("t2_mei", 32'(csr_cause_o), 32'd11);
    int_meip_i = 1'b0;
    repeat (3) step();
    check("t2_msi", 32'(csr_cause_o), 32'd3);
    int_msip_i = 1'b0; int_mtip_i = 1'b0;
    repeat (3) step();

    // Exception, mret and MTI together
    exc_valid_i = 1'b1; exc_cause_i = 4'd5; exc_pc_i = 32'h0000_3000;
    mret_i = 1'b1; mepc_i = 32'h0000_5000; int_mtip_i = 1'b1;
    step();
    exc_valid_i = 1'b0;
    check("t3_exc_intr", 32'(csr_interrupt_o), 32'd0);
    check("t3_exc_cause", 32'(csr_cause_o), 32'd5);
    repeat (3) step();
    check("t3_irq_intr", 32'(csr_interrupt_o), 32'd1);
    check("t3_irq_cause", 32'(csr_cause_o), 32'd7);
    int_mtip_i = 1'b0;
    repeat (3) step();
    check("t3_mret", 32'(csr_mret_o), 32'd1);
    mret_i = 1'b0;
    repeat (3) step();

    // mret with fetch stalled
    clear_inputs();
    mret_i = 1'b1; mepc_i = 32'h0000_2000; fetch_ready_i = 1'b0;
    step();
    mret_i = 1'b0;
    check("t4_mret", 32'(csr_mret_o), 32'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      check("t4_load", 32'(pc_load_o), 32'd1);
      check("t4_target", pc_target_o, 32'h0000_2000);
      if (i == 3) fetch_ready_i = 1'b1;
      step();
    end
    check("t4_idle", 32'(busy_o), 32'd0);
    check("t4_noload", 32'(pc_load_o), 32'd0);

    // Vectored mode target for MTI
    mtvec_i = 32'h0000_0201; int_mtip_i = 1'b1; mie_mtie_i = 1'b1;
    mstatus_mie_i = 1'b1; retire_i = 1'b1;
    step();
    int_mtip_i = 1'b0;
    step();
    check("t5_vec", pc_target_o, VEC_EN ? 32'h0000_021C : 32'h0000_0200);
    repeat (2) step();

    // Reset during REDIRECT
    clear_inputs();
    mret_i = 1'b1; mepc_i = 32'h0000_3000; fetch_ready_i = 1'b0;
    step();
    mret_i = 1'b0;
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("t6_busy", 32'(busy_o), 32'd0);
    check("t6_load", 32'(pc_load_o), 32'd0);
    check("t6_target", pc_target_o, RST_PC);
    check("t6_strobes", {28'd0, flush_o, csr_trap_o, csr_mret_o, csr_interrupt_o}, 32'd0);
    check("t6_csr", {csr_pc_o[27:0], csr_cause_o}, 32'd0);
    step();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rst_i         = ($urandom_range(0, 149) == 0);
      exc_valid_i   = ($urandom_range(0, 4) == 0);
      exc_cause_i   = 4'($urandom);
      exc_pc_i      = $urandom;
      mret_i        = ($urandom_range(0, 4) == 0);
      retire_i      = ($urandom_range(0, 1) == 1);
      next_pc_i     = $urandom;
      int_meip_i    = ($urandom_range(0, 3) == 0);
      int_mtip_i    = ($urandom_range(0, 3) == 0);
      int_msip_i    = ($urandom_range(0, 3) == 0);
      mie_meie_i    = ($urandom_range(0, 1) == 1);
      mie_mtie_i    = ($urandom_range(0, 1) == 1);
      mie_msie_i    = ($urandom_range(0, 1) == 1);
      mstatus_mie_i = ($urandom_range(0, 3) != 0);
      mtvec_i       = $urandom;
      mepc_i        = $urandom;
      fetch_ready_i = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
